// File: rtl/mc_fetch_ctrl.sv
// Multi-cycle fetch/datapath control FSM for the addu/subu/ori/lui/lw/sw/beq/j/jal/jr subset.
// Optional performance counters are built only when MC_PERF_CNT_EN is defined.
module mc_fetch_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             stall,
  output logic             pc_we,
  output logic [1:0]       npc_sel,
  output logic             ir_we,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wb_sel,
  output logic             alu_src,
  output logic             ext_op,
  output logic [2:0]       alu_op,
  output logic             mem_we,
  output logic             retire,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  logic [2:0] state_q, state_d;
  logic [5:0] op_q, funct_q;
  logic       last_state;
  logic       wr_en;
  logic       unused_instr_bits;

  assign unused_instr_bits = ^instr[25:6];

  logic is_r, is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal, is_known;
  assign is_r     = (op_q == OP_RTYPE);
  assign is_addu  = is_r && (funct_q == FN_ADDU);
  assign is_subu  = is_r && (funct_q == FN_SUBU);
  assign is_jr    = is_r && (funct_q == FN_JR);
  assign is_ori   = (op_q == OP_ORI);
  assign is_lui   = (op_q == OP_LUI);
  assign is_lw    = (op_q == OP_LW);
  assign is_sw    = (op_q == OP_SW);
  assign is_beq   = (op_q == OP_BEQ);
  assign is_j     = (op_q == OP_J);
  assign is_jal   = (op_q == OP_JAL);
  assign is_known = is_addu | is_subu | is_jr | is_ori | is_lui | is_lw | is_sw | is_beq | is_j | is_jal;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = S_FETCH;
    last_state = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (is_j || is_jr || !is_known) begin
          state_d    = S_FETCH;
          last_state = 1'b1;
        end else if (is_jal) begin
          state_d = S_WB;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_beq) begin
          state_d    = S_FETCH;
          last_state = 1'b1;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (is_sw) begin
          state_d    = S_FETCH;
          last_state = 1'b1;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        state_d    = S_FETCH;
        last_state = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else if (!stall) begin
      state_q <= state_d;
    end
  end

  // NOTE: the latched opcode/funct need no reset; they are always reloaded in S_FETCH before use.
  always_ff @(posedge clk) begin
    if (!reset && !stall && (state_q == S_FETCH)) begin
      op_q    <= instr[31:26];
      funct_q <= instr[5:0];
    end
  end

  assign wr_en  = !reset && !stall;
  assign pc_we  = wr_en && last_state;
  assign retire = pc_we;
  assign ir_we  = wr_en && (state_q == S_FETCH);
  assign reg_we = wr_en && (state_q == S_WB);
  assign mem_we = wr_en && (state_q == S_MEM) && is_sw;
  assign state  = state_q;

  // Selects follow the latched instruction and are therefore stable for its whole duration.
  assign npc_sel = (is_j || is_jal) ? 2'd2 :
                   is_jr            ? 2'd3 :
                   is_beq           ? {1'b0, zero} : 2'd0;
  assign reg_dst = is_jal ? 2'd2 : (is_r ? 2'd1 : 2'd0);
  assign wb_sel  = is_lw ? 2'd1 : (is_jal ? 2'd2 : 2'd0);
  assign alu_src = is_ori | is_lui | is_lw | is_sw;
  assign ext_op  = is_lw | is_sw;
  assign alu_op  = is_ori ? 3'd2 :
                   is_lui ? 3'd3 :
                   (is_beq || is_subu) ? 3'd1 : 3'd0;

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (retire) instr_cnt_q <= instr_cnt_q + CNT_W'(1);
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_fetch_ctrl.sv
// Bench for mc_fetch_ctrl: per-instruction state-path model checked every cycle,
// plus directed instruction runs with hand-computed cycle counts, state traces and selects.
module tb_mc_fetch_ctrl;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset, zero, stall;
  logic [31:0]      instr;
  logic             pc_we, ir_we, reg_we, alu_src, ext_op, mem_we, retire;
  logic [1:0]       npc_sel, reg_dst, wb_sel;
  logic [2:0]       alu_op, state;
  logic [CNT_W-1:0] cycle_cnt, instr_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mc_fetch_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .stall(stall),
    .pc_we(pc_we), .npc_sel(npc_sel), .ir_we(ir_we), .reg_we(reg_we),
    .reg_dst(reg_dst), .wb_sel(wb_sel), .alu_src(alu_src), .ext_op(ext_op),
    .alu_op(alu_op), .mem_we(mem_we), .retire(retire), .state(state),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef enum int {C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_UNK} cls_t;

  function automatic cls_t classify(logic [31:0] w);
    case (w[31:26])
      6'b000000: case (w[5:0])
        6'b100001: return C_ADDU;
        6'b100011: return C_SUBU;
        6'b001000: return C_JR;
        default:   return C_UNK;
      endcase
      6'b001101: return C_ORI;
      6'b001111: return C_LUI;
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100: return C_BEQ;
      6'b000010: return C_J;
      6'b000011: return C_JAL;
      default:   return C_UNK;
    endcase
  endfunction

  // Sequence of states each instruction class walks through, starting at FETCH.
  function automatic int path_len(cls_t c);
    case (c)
      C_J, C_JR, C_UNK: return 2;
      C_BEQ, C_JAL:     return 3;
      C_LW:             return 5;
      default:          return 4;
    endcase
  endfunction

  function automatic logic [2:0] path_state(cls_t c, int idx);
    logic [2:0] p [5];
    case (c)
      C_J, C_JR, C_UNK: p = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd0};
      C_BEQ:            p = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd0};
      C_JAL:            p = '{3'd0, 3'd1, 3'd4, 3'd0, 3'd0};
      C_SW:             p = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
      C_LW:             p = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
      default:          p = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    endcase
    return p[idx];
  endfunction

  cls_t        m_cls    = C_UNK;
  int          m_idx    = 0;
  logic [31:0] m_cyc    = '0;
  logic [31:0] m_ins    = '0;
  bit          check_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_idx    <= 0;
      m_cyc    <= '0;
      m_ins    <= '0;
      check_en <= 1'b1;
    end else begin
      m_cyc <= m_cyc + 32'd1;
      if (!stall && m_idx != 0 && m_idx == path_len(m_cls) - 1) m_ins <= m_ins + 32'd1;
      if (!stall) begin
        if (m_idx == 0) begin
          m_cls <= classify(instr);
          m_idx <= 1;
        end else if (m_idx == path_len(m_cls) - 1) begin
          m_idx <= 0;
        end else begin
          m_idx <= m_idx + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin : cmp
      automatic logic [2:0] st   = path_state(m_cls, m_idx);
      automatic bit         en   = !reset && !stall;
      automatic bit         last = (m_idx != 0) && (m_idx == path_len(m_cls) - 1);
      check("state", state, st);
      check("pc_we", pc_we, en && last);
      check("retire", retire, en && last);
      check("ir_we", ir_we, en && (m_idx == 0));
      check("reg_we", reg_we, en && (st == 3'd4));
      check("mem_we", mem_we, en && (st == 3'd3) && (m_cls == C_SW));
      if (last) begin
        case (m_cls)
          C_J, C_JAL: check("npc_sel", npc_sel, 2);
          C_JR:       check("npc_sel", npc_sel, 3);
          C_BEQ:      check("npc_sel", npc_sel, zero ? 1 : 0);
          default:    check("npc_sel", npc_sel, 0);
        endcase
      end
      if (st == 3'd4) begin
        check("reg_dst", reg_dst, (m_cls == C_JAL) ? 2 : ((m_cls == C_ADDU || m_cls == C_SUBU) ? 1 : 0));
        check("wb_sel", wb_sel, (m_cls == C_LW) ? 1 : ((m_cls == C_JAL) ? 2 : 0));
      end
      if (m_idx != 0) begin
        case (m_cls)
          C_ORI:       begin check("alu_src", alu_src, 1); check("ext_op", ext_op, 0); check("alu_op", alu_op, 2); end
          C_LUI:       begin check("alu_src", alu_src, 1); check("alu_op", alu_op, 3); end
          C_LW, C_SW:  begin check("alu_src", alu_src, 1); check("ext_op", ext_op, 1); check("alu_op", alu_op, 0); end
          C_BEQ, C_SUBU: begin check("alu_src", alu_src, 0); check("alu_op", alu_op, 1); end
          C_ADDU:      begin check("alu_src", alu_src, 0); check("alu_op", alu_op, 0); end
          default: ;
        endcase
      end
`ifdef MC_PERF_CNT_EN
      check("cycle_cnt", cycle_cnt, m_cyc);
      check("instr_cnt", instr_cnt, m_ins);
`else
      check("cycle_cnt", cycle_cnt, 0);
      check("instr_cnt", instr_cnt, 0);
`endif
    end
  end

  // Runs one instruction from FETCH; the live instr is scrambled after FETCH so only the latched copy is valid.
  task automatic run_instr(input logic [31:0] w, input logic z, input int stall_k, input int stall_n,
                           input int reset_k, output int cycles, output logic [23:0] trace,
                           output logic [1:0] npc, output int n_reg, output int n_mem,
                           output logic [1:0] dst, output logic [1:0] wsel, output int stall_ok);
    int  k = 0;
    int  stalled = 0;
    bit  done = 0;
    cycles = 0; trace = '0; npc = '0; n_reg = 0; n_mem = 0; dst = '0; wsel = '0; stall_ok = 0;
    zero = z;
    for (int c = 0; c < 16 && !done; c++) begin
      instr = (k == 0) ? w : ~w;
      stall = (stall_k >= 0) && (k == stall_k) && (stalled < stall_n);
      reset = (reset_k >= 0) && (k == reset_k);
      @(negedge clk);
      cycles++;
      if (reg_we) begin n_reg++; dst = reg_dst; wsel = wb_sel; end
      if (mem_we) n_mem++;
      if (stall) begin
        stalled++;
        if (state == 3'd2 && !pc_we && !ir_we && !reg_we && !mem_we && !retire) stall_ok++;
      end else begin
        trace = trace | (24'(state) << (3 * k));
        k++;
      end
      if (pc_we) begin npc = npc_sel; done = 1; end
      if (reset) done = 1;
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    reset = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: instr 0x%08h did not retire within 16 cycles", w);
    end
  endtask

  task automatic run_and_check(input string nm, input logic [31:0] w, input logic z, input int sk,
                               input int sn, input int rk, input int e_cyc, input logic [23:0] e_trace,
                               input logic [1:0] e_npc, input int e_reg, input int e_mem,
                               input logic [1:0] e_dst, input logic [1:0] e_wsel, output int stall_ok);
    int cyc, nr, nm_we;
    logic [23:0] tr;
    logic [1:0]  np, d, ws;
    run_instr(w, z, sk, sn, rk, cyc, tr, np, nr, nm_we, d, ws, stall_ok);
    check({nm, "_cycles"}, cyc, e_cyc);
    check({nm, "_trace"}, tr, e_trace);
    check({nm, "_reg_we_cnt"}, nr, e_reg);
    check({nm, "_mem_we_cnt"}, nm_we, e_mem);
    if (rk < 0) check({nm, "_npc"}, np, e_npc);
    if (e_reg > 0) begin
      check({nm, "_reg_dst"}, d, e_dst);
      check({nm, "_wb_sel"}, ws, e_wsel);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int so;
    reset = 1'b1; stall = 1'b0; zero = 1'b0; instr = '0;
    @(posedge clk);
    @(negedge clk);
    check("reset_state", state, 0);
    check("reset_ir_we", ir_we, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    //            name       instr         z  sk sn rk cyc trace      npc reg mem dst wsel
    run_and_check("addu",  32'h00851021, 0, -1, 0, -1, 4, 24'h888,  0, 1, 0, 1, 0, so);
    run_and_check("lw",    32'h8C880004, 0, -1, 0, -1, 5, 24'h4688, 0, 1, 0, 0, 1, so);
    run_and_check("sw",    32'hAC880008, 0, -1, 0, -1, 4, 24'h688,  0, 0, 1, 0, 0, so);
    run_and_check("beq_t", 32'h10850003, 1, -1, 0, -1, 3, 24'h88,   1, 0, 0, 0, 0, so);
    run_and_check("beq_f", 32'h10850003, 0, -1, 0, -1, 3, 24'h88,   0, 0, 0, 0, 0, so);
    run_and_check("jal",   32'h0C000C00, 0, -1, 0, -1, 3, 24'h108,  2, 1, 0, 2, 2, so);
    run_and_check("jr",    32'h03E00008, 0, -1, 0, -1, 2, 24'h08,   3, 0, 0, 0, 0, so);
    run_and_check("j",     32'h08000010, 0, -1, 0, -1, 2, 24'h08,   2, 0, 0, 0, 0, so);
    run_and_check("unk_op",32'hFC000000, 0, -1, 0, -1, 2, 24'h08,   0, 0, 0, 0, 0, so);
    run_and_check("unk_fn",32'h00000000, 0, -1, 0, -1, 2, 24'h08,   0, 0, 0, 0, 0, so);
    run_and_check("subu",  32'h00851023, 0, -1, 0, -1, 4, 24'h888,  0, 1, 0, 1, 0, so);
    run_and_check("lui",   32'h3C051234, 0, -1, 0, -1, 4, 24'h888,  0, 1, 0, 0, 0, so);

    run_and_check("ori_stall", 32'h34A500FF, 0, 2, 3, -1, 7, 24'h888, 0, 1, 0, 0, 0, so);
    check("ori_stall_hold_cycles", so, 3);
    run_and_check("addu_fstall", 32'h00851021, 0, 0, 2, -1, 6, 24'h888, 0, 1, 0, 1, 0, so);

    run_and_check("lw_reset", 32'h8C880004, 0, -1, 0, 3, 4, 24'h688, 0, 0, 0, 0, 0, so);
    check("lw_reset_state", state, 0);
    run_and_check("sw_rst_stall", 32'hAC880008, 0, 3, 1, 3, 4, 24'h88, 0, 0, 0, 0, 0, so);
    check("sw_rst_stall_state", state, 0);
    run_and_check("addu_after_rst", 32'h00851021, 0, -1, 0, -1, 4, 24'h888, 0, 1, 0, 1, 0, so);

    do_reset(1);
    run_and_check("cnt_addu", 32'h00851021, 0, -1, 0, -1, 4, 24'h888, 0, 1, 0, 1, 0, so);
    run_and_check("cnt_beq",  32'h10850003, 0, -1, 0, -1, 3, 24'h88,  0, 0, 0, 0, 0, so);
    run_and_check("cnt_jr",   32'h03E00008, 0, -1, 0, -1, 2, 24'h08,  3, 0, 0, 0, 0, so);
`ifdef MC_PERF_CNT_EN
    check("perf_cycle_cnt", cycle_cnt, 9);
    check("perf_instr_cnt", instr_cnt, 3);
`else
    check("perf_cycle_cnt", cycle_cnt, 0);
    check("perf_instr_cnt", instr_cnt, 0);
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
